// File: rtl/uart_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_arbiter
// Brief    : Word-granular arbiter for a shared 32-bit UART word serializer.
//            Requester 0 has strict priority; the rest share bounded-burst RR.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 8,
    parameter int ACC_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   word_flat,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      ack,
    output logic [31:0]             ser_data,
    output logic                    ser_en,
    input  logic                    ser_idle,
    output logic                    busy,
    output logic                    timeout_err,
    input  logic                    err_clr
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(ACC_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WAIT_ACC  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic [31:0]        r_ser_data;
    logic               r_ser_en;
    logic               r_timeout_err;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_last_owner;
    logic [IW-1:0]      r_rr_ptr;
    logic [7:0]         r_burst;
    logic [TW-1:0]      r_acc_cnt;

    logic [IW-1:0]      w_cand;
    logic [IW-1:0]      w_alt;
    logic [IW-1:0]      w_win;
    logic               w_cand_vld;
    logic               w_alt_vld;
    logic               w_skip;
    logic               w_win_vld;
    logic               w_go;
    logic               w_timeout;
    logic [TW-1:0]      w_acc_cnt_nxt;

    // Round-robin indices live in 1..NUM_REQ-1; index 0 is never part of the ring.
    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
        if (int'(idx) >= NUM_REQ - 1)
            return IW'(1);
        return idx + IW'(1);
    endfunction

    function automatic logic [IW-1:0] rr_offset(input logic [IW-1:0] base, input int k);
        int pos;
        pos = ((int'(base) - 1 + k) % (NUM_REQ - 1)) + 1;
        return IW'(pos);
    endfunction

    // w_alt is the next pending RR requester after the candidate, used when the
    // candidate has used up its burst allowance.
    always_comb begin
        w_cand     = '0;
        w_cand_vld = 1'b0;
        w_alt      = '0;
        w_alt_vld  = 1'b0;
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            if (!w_cand_vld && req[rr_offset(r_rr_ptr, k)]) begin
                w_cand     = rr_offset(r_rr_ptr, k);
                w_cand_vld = 1'b1;
            end
        end
        for (int k = 1; k < NUM_REQ - 1; k++) begin
            if (!w_alt_vld && req[rr_offset(w_cand, k)]) begin
                w_alt     = rr_offset(w_cand, k);
                w_alt_vld = 1'b1;
            end
        end
    end

    assign w_skip        = w_cand_vld && w_alt_vld && (w_cand == r_last_owner)
                           && (r_burst == 8'(MAX_BURST));
    assign w_win_vld     = req[0] | w_cand_vld;
    assign w_win         = req[0] ? '0 : (w_skip ? w_alt : w_cand);
    assign w_go          = (r_state == S_IDLE) && ser_idle && w_win_vld;
    assign w_acc_cnt_nxt = r_acc_cnt + TW'(1);
    assign w_timeout     = (r_state == S_WAIT_ACC) && ser_idle
                           && (w_acc_cnt_nxt == TW'(ACC_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_go) w_state_nxt = S_LOAD;
            S_LOAD:      w_state_nxt = S_WAIT_ACC;
            S_WAIT_ACC: begin
                if (!ser_idle)
                    w_state_nxt = S_WAIT_DONE;
                else if (w_timeout)
                    w_state_nxt = S_IDLE;
            end
            S_WAIT_DONE: if (ser_idle) w_state_nxt = S_ACK;
            S_ACK:       w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        grant       = r_grant;
        ack         = r_ack;
        ser_data    = r_ser_data;
        ser_en      = r_ser_en;
        timeout_err = r_timeout_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_ack         <= '0;
            r_ser_data    <= '0;
            r_ser_en      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_owner       <= '0;
            r_last_owner  <= '0;
            r_rr_ptr      <= IW'(1);
            r_burst       <= 8'd0;
            r_acc_cnt     <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_grant    <= NUM_REQ'(1) << w_win;
                        r_ser_data <= word_flat[32*int'(w_win) +: 32];
                        r_owner    <= w_win;
                        if (w_win != '0) begin
                            if (w_win == r_last_owner) begin
                                if (r_burst != 8'hFF)
                                    r_burst <= r_burst + 8'd1;
                            end else begin
                                r_burst      <= 8'd1;
                                r_last_owner <= w_win;
                                r_rr_ptr     <= rr_next(w_win);
                            end
                        end
                    end else begin
                        r_grant <= '0;
                    end
                end
                S_LOAD: begin
                    r_ser_en  <= 1'b1;
                    r_acc_cnt <= '0;
                end
                S_WAIT_ACC: begin
                    if (!ser_idle) begin
                        r_ser_en <= 1'b0;
                    end else if (w_timeout) begin
                        r_ser_en <= 1'b0;
                        r_grant  <= '0;
                        if (r_owner != '0)
                            r_rr_ptr <= rr_next(r_owner);
                    end else begin
                        r_acc_cnt <= w_acc_cnt_nxt;
                    end
                end
                S_WAIT_DONE: if (ser_idle) r_ack <= r_grant;
                default: ;
            endcase

            if (w_timeout)
                r_timeout_err <= 1'b1;
            else if (err_clr)
                r_timeout_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_arbiter
// Brief    : Directed bench for uart_word_arbiter with a simple serializer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int MAX_BURST   = 8;
    localparam int ACC_TIMEOUT = 64;
    localparam int SER_ACC_DLY = 3;
    localparam int SER_BUSY    = 40;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] word_flat;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    ack;
    logic [31:0]           ser_data;
    logic                  ser_en;
    logic                  ser_idle;
    logic                  busy;
    logic                  timeout_err;
    logic                  err_clr;

    int          checks = 0;
    int          errors = 0;
    int          rem  [NUM_REQ];
    int          sent [NUM_REQ];
    int          ack_log[$];
    logic [31:0] acc_log[$];
    int          ack_cnt;
    bit          model_en;
    bit          accept_en;
    int          ser_phase;
    int          ser_cnt;

    uart_word_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .MAX_BURST   (MAX_BURST),
        .ACC_TIMEOUT (ACC_TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .word_flat   (word_flat),
        .grant       (grant),
        .ack         (ack),
        .ser_data    (ser_data),
        .ser_en      (ser_en),
        .ser_idle    (ser_idle),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkword(input int i, input int n);
        return 32'hC0DE_0000 | (32'(i) << 12) | 32'(n & 32'hFFF);
    endfunction

    task automatic set_req(input int i, input int n, input logic [31:0] w);
        rem[i] = n;
        req[i] = (n != 0);
        word_flat[32*i +: 32] = w;
    endtask

    // One clock: sample after the edge, then play requesters and serializer.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack[i]) begin
                ack_log.push_back(i);
                ack_cnt++;
                if (rem[i] > 0) rem[i]--;
                sent[i]++;
                req[i] = (rem[i] != 0);
                word_flat[32*i +: 32] = mkword(i, sent[i]);
            end
        end
        if (model_en) begin
            case (ser_phase)
                0: if (ser_en && accept_en) begin ser_phase = 1; ser_cnt = 1; end
                1: begin
                    ser_cnt++;
                    if (ser_cnt == SER_ACC_DLY) begin
                        acc_log.push_back(ser_data);
                        ser_idle  = 1'b0;
                        ser_phase = 2;
                        ser_cnt   = 0;
                    end
                end
                default: begin
                    ser_cnt++;
                    if (ser_cnt == SER_BUSY) begin ser_idle = 1'b1; ser_phase = 0; end
                end
            endcase
        end
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        err_clr = 1'b0;
        req = '0;
        word_flat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin rem[i] = 0; sent[i] = 0; end
        ack_log.delete();
        acc_log.delete();
        ack_cnt = 0;
        model_en = 1'b1;
        accept_en = 1'b1;
        ser_phase = 0;
        ser_cnt = 0;
        ser_idle = 1'b1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_acks(input int target, input int max_cyc, output bit ok);
        int c = 0;
        while (ack_cnt < target && c < max_cyc) begin cycle(); c++; end
        ok = (ack_cnt >= target);
    endtask

    task automatic wait_phase2(input int max_cyc, output bit ok);
        int c = 0;
        while (ser_phase != 2 && c < max_cyc) begin cycle(); c++; end
        ok = (ser_phase == 2);
    endtask

    task automatic test_reset();
        assert_reset();
        cycle();
        cycle();
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
        checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (ser_data !== 32'h0) begin errors++; $display("FAIL reset_ser_data: got %h expected 0", ser_data); end
        checks++; if (ser_en !== 1'b0) begin errors++; $display("FAIL reset_ser_en: got %b expected 0", ser_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        release_reset();
        cycle();
        checks++; if (busy !== 1'b0 || grant !== '0) begin errors++; $display("FAIL reset_idle_noreq: busy=%b grant=%b expected 0/0", busy, grant); end
    endtask

    task automatic test_idle_gating();
        bit ok;
        assert_reset();
        model_en = 1'b0;
        ser_idle = 1'b0;
        set_req(0, 1, 32'hCAFE_0001);
        cycle();
        release_reset();
        repeat (5) cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_busy: got %b expected 0", busy); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL gate_grant: got %b expected 0000", grant); end
        ser_idle = 1'b1;
        cycle();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL gate_grant_after_idle: got %b expected 0001", grant); end
        model_en = 1'b1;
        wait_acks(1, 200, ok);
        checks++; if (!ok || ack !== 4'b0001) begin errors++; $display("FAIL gate_ack: got %b expected 0001 (seen=%0d)", ack, ok); end
        checks++; if (acc_log.size() != 1 || acc_log[0] !== 32'hCAFE_0001) begin errors++; $display("FAIL gate_word: got %0d words, expected one word cafe0001", acc_log.size()); end
    endtask

    task automatic test_single_word();
        bit ok;
        int en_hi;
        assert_reset();
        release_reset();
        set_req(1, 1, 32'h1234_5678);
        cycle();
        checks++; if (grant !== 4'b0010 || ser_en !== 1'b0) begin errors++; $display("FAIL single_grant: grant=%b ser_en=%b expected 0010/0", grant, ser_en); end
        checks++; if (ser_data !== 32'h1234_5678) begin errors++; $display("FAIL single_data: got %h expected 12345678", ser_data); end
        cycle();
        checks++; if (ser_en !== 1'b1) begin errors++; $display("FAIL single_en_latency: got %b expected 1", ser_en); end
        en_hi = 1;
        for (int c = 0; c < 20 && ser_phase != 2; c++) begin
            cycle();
            if (ser_en) en_hi++;
        end
        checks++; if (en_hi != SER_ACC_DLY) begin errors++; $display("FAIL single_en_hold: got %0d cycles expected %0d", en_hi, SER_ACC_DLY); end
        cycle();
        checks++; if (ser_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_accepted: ser_en=%b busy=%b expected 0/1", ser_en, busy); end
        wait_acks(1, 100, ok);
        checks++; if (!ok || ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b expected 0010", ack); end
        cycle();
        checks++; if (ack !== 4'b0000 || grant !== 4'b0010) begin errors++; $display("FAIL single_ack_pulse: ack=%b grant=%b expected 0000/0010", ack, grant); end
        cycle();
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: grant=%b busy=%b expected 0000/0", grant, busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_ord[6] = '{1, 2, 3, 1, 2, 3};
        int exp_n[6]   = '{0, 0, 0, 1, 1, 1};
        assert_reset();
        release_reset();
        for (int i = 1; i < NUM_REQ; i++) set_req(i, 2, mkword(i, 0));
        wait_acks(6, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_six_acks: got %0d acks expected 6", ack_cnt); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (ack_log.size() <= k || ack_log[k] != exp_ord[k] || acc_log[k] !== mkword(exp_ord[k], exp_n[k])) begin
                errors++;
                $display("FAIL rr_order_%0d: got req %0d expected req %0d word %h", k,
                         (ack_log.size() > k) ? ack_log[k] : -1, exp_ord[k], mkword(exp_ord[k], exp_n[k]));
            end
        end
        set_req(2, 1, mkword(2, sent[2]));
        set_req(1, 1, mkword(1, sent[1]));
        wait_acks(8, 300, ok);
        checks++; if (!ok || ack_log[6] != 1 || ack_log[7] != 2) begin errors++; $display("FAIL rr_wrap: got %0d acks expected order 1,2 after wrap", ack_cnt); end
    endtask

    task automatic test_priority_burst();
        bit ok;
        int start;
        int run2;
        int exp_ord[4] = '{2, 2, 0, 2};
        assert_reset();
        release_reset();
        set_req(2, 1000, mkword(2, 0));
        wait_acks(1, 200, ok);
        wait_phase2(100, ok);
        set_req(0, 1, 32'h5A5A_0000);
        wait_acks(4, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_acks: got %0d acks expected 4", ack_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ack_log.size() <= k || ack_log[k] != exp_ord[k]) begin
                errors++;
                $display("FAIL prio_order_%0d: got %0d expected %0d", k, (ack_log.size() > k) ? ack_log[k] : -1, exp_ord[k]);
            end
        end
        checks++; if (acc_log.size() < 3 || acc_log[2] !== 32'h5A5A_0000) begin errors++; $display("FAIL prio_word: expected 5a5a0000 as third accepted word"); end
        wait_phase2(100, ok);
        set_req(3, 2, mkword(3, 0));
        start = ack_log.size();
        for (int c = 0; c < 2000 && sent[3] < 2; c++) cycle();
        checks++; if (sent[3] != 2) begin errors++; $display("FAIL burst_req3_served: got %0d words expected 2", sent[3]); end
        run2 = 0;
        for (int k = start; k < ack_log.size() && ack_log[k] != 3; k++) run2++;
        checks++; if (run2 < 1 || run2 > MAX_BURST) begin errors++; $display("FAIL burst_bound: got %0d words of req2 before req3, expected 1..%0d", run2, MAX_BURST); end
    endtask

    task automatic test_timeout();
        bit ok;
        int en_hi;
        assert_reset();
        release_reset();
        accept_en = 1'b0;
        set_req(1, 1, 32'hAAAA_0001);
        set_req(2, 1, 32'hBBBB_0002);
        for (int c = 0; c < 10 && !ser_en; c++) cycle();
        en_hi = 0;
        for (int c = 0; c < 200 && ser_en; c++) begin en_hi++; cycle(); end
        checks++; if (en_hi != ACC_TIMEOUT) begin errors++; $display("FAIL to_en_cycles: got %0d expected %0d", en_hi, ACC_TIMEOUT); end
        checks++; if (timeout_err !== 1'b1 || grant !== 4'b0000) begin errors++; $display("FAIL to_flag: err=%b grant=%b expected 1/0000", timeout_err, grant); end
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL to_no_ack: got %0d acks expected 0", ack_cnt); end
        accept_en = 1'b1;
        cycle();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL to_next_grant: got %b expected 0100", grant); end
        wait_acks(1, 200, ok);
        checks++; if (!ok || ack !== 4'b0100 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: ack=%b err=%b expected 0100/1", ack, timeout_err); end
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", timeout_err); end
        wait_acks(2, 200, ok);
        checks++; if (!ok || ack_log[1] != 1 || acc_log[1] !== 32'hAAAA_0001) begin errors++; $display("FAIL to_retry: got %0d acks expected req1 word aaaa0001 second", ack_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        assert_reset();
        release_reset();
        set_req(3, 1, 32'hDEAD_BEEF);
        wait_phase2(50, ok);
        cycle();
        cycle();
        checks++; if (busy !== 1'b1 || ser_en !== 1'b0 || grant !== 4'b1000) begin errors++; $display("FAIL mid_wait_done: busy=%b ser_en=%b grant=%b expected 1/0/1000", busy, ser_en, grant); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || ack !== '0 || ser_data !== 32'h0 || ser_en !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: grant=%b ack=%b data=%h en=%b busy=%b err=%b expected all 0",
                     grant, ack, ser_data, ser_en, busy, timeout_err);
        end
        ser_phase = 0;
        ser_cnt = 0;
        ser_idle = 1'b1;
        cycle();
        cycle();
        release_reset();
        wait_acks(1, 200, ok);
        checks++; if (!ok || ack_cnt != 1 || ack_log[0] != 3) begin errors++; $display("FAIL mid_restart_ack: got %0d acks expected one from req3", ack_cnt); end
        checks++; if (acc_log.size() != 2 || acc_log[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_restart_word: got %0d loads expected 2 of deadbeef", acc_log.size()); end
    endtask

    initial begin
        test_reset();
        test_idle_gating();
        test_single_word();
        test_round_robin();
        test_priority_burst();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
